// File: rtl/ir_phase_sequencer_if.sv
// Handshake/status bundle between the phase sequencer and the scheduler.
// slave = sequencer side, master = scheduler/engine side.
interface ir_phase_sequencer_if;
    logic        iEn;
    logic        iCfgByWhich;
    logic        iCycleReq;
    logic        oCfgStart;
    logic        iCfgDone;
    logic        iCfgErr;
    logic        oCapStart;
    logic        iCapDone;
    logic        oUplStart;
    logic        iUplDone;
    logic [1:0]  oMUX_SEL;
    logic        oBusy;
    logic        oErr;
    logic [1:0]  oErrCode;
    logic        oAbort;
    logic [15:0] oFrameCnt;
    logic        oLED_Configuring;
    logic        oLED_Capturing;
    logic        oLED_Uploading;

    modport slave (
        input  iEn, iCfgByWhich, iCycleReq, iCfgDone, iCfgErr, iCapDone, iUplDone,
        output oCfgStart, oCapStart, oUplStart, oMUX_SEL, oBusy, oErr, oErrCode,
               oAbort, oFrameCnt, oLED_Configuring, oLED_Capturing, oLED_Uploading
    );

    modport master (
        output iEn, iCfgByWhich, iCycleReq, iCfgDone, iCfgErr, iCapDone, iUplDone,
        input  oCfgStart, oCapStart, oUplStart, oMUX_SEL, oBusy, oErr, oErrCode,
               oAbort, oFrameCnt, oLED_Configuring, oLED_Capturing, oLED_Uploading
    );
endinterface

// File: rtl/ir_phase_sequencer.sv
// IR pin-bank phase sequencer: CFG -> CAP -> UPL with mux guard intervals and per-phase watchdogs.
// Optional IR_SEQ_AUTORUN_EN: chain straight into the next capture when a request is pending at upload done.
module ir_phase_sequencer #(
    parameter int          GUARD_CYCLES   = 16,
    parameter int          TO_W           = 24,
    parameter int          TIMEOUT_CYCLES = 2000000,
    parameter logic [1:0]  MUX_CFG        = 2'b01,
    parameter logic [1:0]  MUX_CAP        = 2'b00,
    parameter logic [1:0]  MUX_UPL        = 2'b10,
    parameter logic [15:0] FRAME_CNT_RST  = 16'h0000
) (
    input  logic                  iClk,
    input  logic                  iRst_N,
    ir_phase_sequencer_if.slave   bus
);
    localparam int              GW         = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_GUARD, ST_CFG_RUN, ST_CAP_RUN, ST_UPL_RUN, ST_ERROR
    } state_e;

    typedef enum logic [1:0] {TGT_CFG, TGT_CAP, TGT_UPL} tgt_e;

    state_e          state_q, state_d;
    tgt_e            tgt_q, tgt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]      mux_q, mux_d;
    logic            cfg_ok_q, cfg_ok_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            cfg_start_q, cfg_start_d;
    logic            cap_start_q, cap_start_d;
    logic            upl_start_q, upl_start_d;
    logic            abort_q, abort_d;
    logic            timeout;

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_CAP;
            gcnt_q      <= '0;
            tcnt_q      <= '0;
            mux_q       <= MUX_CAP;
            cfg_ok_q    <= 1'b0;
            err_code_q  <= 2'd0;
            frame_cnt_q <= FRAME_CNT_RST;
            cfg_start_q <= 1'b0;
            cap_start_q <= 1'b0;
            upl_start_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            gcnt_q      <= gcnt_d;
            tcnt_q      <= tcnt_d;
            mux_q       <= mux_d;
            cfg_ok_q    <= cfg_ok_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
            cfg_start_q <= cfg_start_d;
            cap_start_q <= cap_start_d;
            upl_start_q <= upl_start_d;
            abort_q     <= abort_d;
        end
    end

    assign timeout = (tcnt_q == TO_LAST);

    // Guard and timeout counters default to zero so every entry into GUARD/RUN starts clean.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        gcnt_d      = '0;
        tcnt_d      = '0;
        mux_d       = mux_q;
        cfg_ok_d    = cfg_ok_q;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        cfg_start_d = 1'b0;
        cap_start_d = 1'b0;
        upl_start_d = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.iEn && bus.iCycleReq) begin
                    state_d = ST_GUARD;
                    if (bus.iCfgByWhich && !cfg_ok_q) begin
                        tgt_d = TGT_CFG;
                        mux_d = MUX_CFG;
                    end else begin
                        tgt_d = TGT_CAP;
                        mux_d = MUX_CAP;
                    end
                end
            end
            ST_GUARD: begin
                if (!bus.iEn) begin
                    state_d = ST_IDLE;
                    mux_d   = MUX_CAP;
                    abort_d = 1'b1;
                end else if (gcnt_q == GUARD_LAST) begin
                    case (tgt_q)
                        TGT_CFG: begin state_d = ST_CFG_RUN; cfg_start_d = 1'b1; end
                        TGT_UPL: begin state_d = ST_UPL_RUN; upl_start_d = 1'b1; end
                        default: begin state_d = ST_CAP_RUN; cap_start_d = 1'b1; end
                    endcase
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            ST_CFG_RUN, ST_CAP_RUN, ST_UPL_RUN: begin
                tcnt_d = tcnt_q + 1'b1;
                if (!bus.iEn) begin
                    state_d = ST_IDLE;
                    mux_d   = MUX_CAP;
                    abort_d = 1'b1;
                end else if (state_q == ST_CFG_RUN && bus.iCfgDone) begin
                    cfg_ok_d = 1'b1;
                    state_d  = ST_GUARD;
                    tgt_d    = TGT_CAP;
                    mux_d    = MUX_CAP;
                end else if (state_q == ST_CAP_RUN && bus.iCapDone) begin
                    state_d = ST_GUARD;
                    tgt_d   = TGT_UPL;
                    mux_d   = MUX_UPL;
                end else if (state_q == ST_UPL_RUN && bus.iUplDone) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    mux_d       = MUX_CAP;
`ifdef IR_SEQ_AUTORUN_EN
                    if (bus.iCycleReq) begin
                        state_d = ST_GUARD;
                        tgt_d   = TGT_CAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else if (timeout || (state_q == ST_CFG_RUN && bus.iCfgErr)) begin
                    state_d  = ST_ERROR;
                    mux_d    = MUX_CAP;
                    cfg_ok_d = 1'b0;
                    case (state_q)
                        ST_CFG_RUN: err_code_d = 2'd1;
                        ST_CAP_RUN: err_code_d = 2'd2;
                        default:    err_code_d = 2'd3;
                    endcase
                end
            end
            ST_ERROR: begin
                if (!bus.iEn) begin
                    state_d    = ST_IDLE;
                    err_code_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mux_d   = MUX_CAP;
            end
        endcase
    end

    assign bus.oCfgStart        = cfg_start_q;
    assign bus.oCapStart        = cap_start_q;
    assign bus.oUplStart        = upl_start_q;
    assign bus.oMUX_SEL         = mux_q;
    assign bus.oBusy            = (state_q != ST_IDLE);
    assign bus.oErr             = (state_q == ST_ERROR);
    assign bus.oErrCode         = err_code_q;
    assign bus.oAbort           = abort_q;
    assign bus.oFrameCnt        = frame_cnt_q;
    assign bus.oLED_Configuring = (state_q == ST_CFG_RUN) || (state_q == ST_GUARD && tgt_q == TGT_CFG);
    assign bus.oLED_Capturing   = (state_q == ST_CAP_RUN) || (state_q == ST_GUARD && tgt_q == TGT_CAP);
    assign bus.oLED_Uploading   = (state_q == ST_UPL_RUN) || (state_q == ST_GUARD && tgt_q == TGT_UPL);
endmodule

// File: tb/tb_ir_phase_sequencer.sv
// Directed bench for ir_phase_sequencer; a second instance preloaded to 0xFFFF mirrors the inputs to observe counter wrap.
module tb_ir_phase_sequencer;
    localparam int G  = 4;
    localparam int TO = 100;

    logic iClk   = 1'b0;
    logic iRst_N = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 iClk = ~iClk;

    ir_phase_sequencer_if m();
    ir_phase_sequencer_if w();

    assign w.iEn         = m.iEn;
    assign w.iCfgByWhich = m.iCfgByWhich;
    assign w.iCycleReq   = m.iCycleReq;
    assign w.iCfgDone    = m.iCfgDone;
    assign w.iCfgErr     = m.iCfgErr;
    assign w.iCapDone    = m.iCapDone;
    assign w.iUplDone    = m.iUplDone;

    ir_phase_sequencer #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
        .iClk(iClk), .iRst_N(iRst_N), .bus(m.slave)
    );

    ir_phase_sequencer #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO), .FRAME_CNT_RST(16'hFFFF)) dut_w (
        .iClk(iClk), .iRst_N(iRst_N), .bus(w.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [2:0] starts();
        return {m.oCfgStart, m.oCapStart, m.oUplStart};
    endfunction

    function automatic logic [2:0] leds();
        return {m.oLED_Configuring, m.oLED_Capturing, m.oLED_Uploading};
    endfunction

    // Called in the first GUARD cycle; returns in the first RUN cycle.
    task automatic run_guard(input string tag, input logic [2:0] exp);
        logic [2:0] seen;
        seen = starts();
        for (int i = 0; i < G - 1; i++) begin
            step();
            m.iCfgDone = 1'b0; m.iCfgErr = 1'b0; m.iCapDone = 1'b0; m.iUplDone = 1'b0;
            seen |= starts();
        end
        chk({tag, "_guard_quiet"}, 32'(seen), 32'd0);
        step();
        chk({tag, "_start"}, 32'(starts()), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] seen;
        m.iEn = 1'b0; m.iCfgByWhich = 1'b1; m.iCycleReq = 1'b0;
        m.iCfgDone = 1'b0; m.iCfgErr = 1'b0; m.iCapDone = 1'b0; m.iUplDone = 1'b0;
        repeat (3) step();
        chk("rst_mux",    32'(m.oMUX_SEL), 32'd0);
        chk("rst_flags",  32'({m.oBusy, m.oErr, m.oAbort, m.oErrCode}), 32'd0);
        chk("rst_starts", 32'(starts()), 32'd0);
        chk("rst_leds",   32'(leds()), 32'd0);
        chk("rst_frame",  32'(m.oFrameCnt), 32'd0);
        iRst_N = 1'b1;
        step();
        chk("idle_busy", 32'(m.oBusy), 32'd0);

        // Full sequence with the FPGA configuring the sensor
        m.iEn = 1'b1; m.iCycleReq = 1'b1;
        step();
        m.iCycleReq = 1'b0;
        chk("t1_mux_cfg", 32'(m.oMUX_SEL), 32'd1);
        chk("t1_leds_cfg", 32'(leds()), 32'b100);
        chk("t1_busy", 32'(m.oBusy), 32'd1);
        run_guard("t1_cfg", 3'b100);
        step();
        chk("t1_cfg_pulse_len", 32'(starts()), 32'd0);
        repeat (3) step();
        m.iCfgDone = 1'b1; step(); m.iCfgDone = 1'b0;
        chk("t1_mux_cap", 32'(m.oMUX_SEL), 32'd0);
        chk("t1_leds_cap", 32'(leds()), 32'b010);
        run_guard("t1_cap", 3'b010);
        m.iCapDone = 1'b1; step(); m.iCapDone = 1'b0;
        chk("t1_mux_upl", 32'(m.oMUX_SEL), 32'd2);
        chk("t1_leds_upl", 32'(leds()), 32'b001);
        run_guard("t1_upl", 3'b001);
        m.iUplDone = 1'b1; step(); m.iUplDone = 1'b0;
        chk("t1_frame", 32'(m.oFrameCnt), 32'd1);
        chk("t1_idle", 32'({m.oBusy, m.oMUX_SEL}), 32'd0);
        chk("t1_wrap", 32'(w.oFrameCnt), 32'd0);

        // cfg_ok set: CFG skipped; stray done/err pulses during GUARD are ignored
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        chk("t2_mux", 32'(m.oMUX_SEL), 32'd0);
        chk("t2_leds", 32'(leds()), 32'b010);
        m.iCfgDone = 1'b1; m.iCfgErr = 1'b1; m.iUplDone = 1'b1;
        run_guard("t2_cap", 3'b010);
        m.iCapDone = 1'b1; step(); m.iCapDone = 1'b0;
        run_guard("t2_upl", 3'b001);
        m.iUplDone = 1'b1; step(); m.iUplDone = 1'b0;
        chk("t2_frame", 32'(m.oFrameCnt), 32'd2);

        // Capture timeout
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        run_guard("t3_cap", 3'b010);
        repeat (TO - 1) step();
        chk("t3_err_edge", 32'(m.oErr), 32'd0);
        step();
        chk("t3_err", 32'(m.oErr), 32'd1);
        chk("t3_code", 32'(m.oErrCode), 32'd2);
        chk("t3_mux", 32'(m.oMUX_SEL), 32'd0);
        repeat (5) step();
        chk("t3_err_hold", 32'({m.oErr, m.oBusy}), 32'b11);
        m.iEn = 1'b0; step();
        chk("t3_clear", 32'({m.oErr, m.oErrCode, m.oBusy, m.oAbort}), 32'd0);
        m.iEn = 1'b1;
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        chk("t3_rerun_cfg_mux", 32'(m.oMUX_SEL), 32'd1);
        run_guard("t3_cfg", 3'b100);
        m.iCfgDone = 1'b1; step(); m.iCfgDone = 1'b0;
        run_guard("t4_cap", 3'b010);

        // Done on the expiring timeout cycle wins
        repeat (TO - 1) step();
        m.iCapDone = 1'b1; step(); m.iCapDone = 1'b0;
        chk("t4_no_err", 32'(m.oErr), 32'd0);
        chk("t4_mux_upl", 32'(m.oMUX_SEL), 32'd2);
        run_guard("t4_upl", 3'b001);
        m.iUplDone = 1'b1; step(); m.iUplDone = 1'b0;
        chk("t4_frame", 32'(m.oFrameCnt), 32'd3);

        // Abort mid-GUARD
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        step();
        m.iEn = 1'b0; step();
        chk("t5_abort", 32'(m.oAbort), 32'd1);
        chk("t5_idle", 32'({m.oBusy, m.oMUX_SEL}), 32'd0);
        step();
        chk("t5_abort_once", 32'(m.oAbort), 32'd0);
        seen = starts();
        repeat (4) begin step(); seen |= starts(); end
        chk("t5_no_start", 32'(seen), 32'd0);
        chk("t5_frame", 32'(m.oFrameCnt), 32'd3);
        m.iEn = 1'b1;

        // Abort in UPL_RUN beats a simultaneous upload done
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        run_guard("t5b_cap", 3'b010);
        m.iCapDone = 1'b1; step(); m.iCapDone = 1'b0;
        run_guard("t5b_upl", 3'b001);
        m.iEn = 1'b0; m.iUplDone = 1'b1; step(); m.iUplDone = 1'b0;
        chk("t5b_abort", 32'(m.oAbort), 32'd1);
        chk("t5b_frame", 32'(m.oFrameCnt), 32'd3);
        m.iEn = 1'b1;

        // Request held high across the upload completion
        m.iCycleReq = 1'b1; step();
        run_guard("t6_cap", 3'b010);
        m.iCapDone = 1'b1; step(); m.iCapDone = 1'b0;
        run_guard("t6_upl", 3'b001);
        m.iUplDone = 1'b1; step(); m.iUplDone = 1'b0;
        chk("t6_frame", 32'(m.oFrameCnt), 32'd4);
        chk("t6_mux", 32'(m.oMUX_SEL), 32'd0);
`ifdef IR_SEQ_AUTORUN_EN
        chk("t6_busy_held", 32'(m.oBusy), 32'd1);
        chk("t6_leds", 32'(leds()), 32'b010);
        run_guard("t6_auto", 3'b010);
`else
        chk("t6_busy_drop", 32'(m.oBusy), 32'd0);
        step();
        chk("t6_restart", 32'({m.oBusy, leds()}), 32'b1010);
`endif
        m.iCycleReq = 1'b0; m.iEn = 1'b0; step(); m.iEn = 1'b1;
        chk("t6_idle", 32'(m.oBusy), 32'd0);

        // Fresh reset with external MCU configuring: CFG skipped
        iRst_N = 1'b0; step();
        chk("t7_rst_frame", 32'(m.oFrameCnt), 32'd0);
        iRst_N = 1'b1; m.iCfgByWhich = 1'b0;
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        chk("t7_mux", 32'(m.oMUX_SEL), 32'd0);
        run_guard("t7_cap", 3'b010);
        m.iEn = 1'b0; step(); m.iEn = 1'b1;

        // Configure error pulse
        m.iCfgByWhich = 1'b1;
        m.iCycleReq = 1'b1; step(); m.iCycleReq = 1'b0;
        chk("t8_mux_cfg", 32'(m.oMUX_SEL), 32'd1);
        run_guard("t8_cfg", 3'b100);
        m.iCfgErr = 1'b1; step(); m.iCfgErr = 1'b0;
        chk("t8_err", 32'({m.oErr, m.oErrCode, m.oMUX_SEL}), 32'b10100);
        m.iEn = 1'b0; step();
        chk("t8_clear", 32'({m.oErr, m.oErrCode}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
